// File: rtl/rx_word_arbiter_1553.sv
// rtl/rx_word_arbiter_1553.sv - N-channel 1553 receive-word capture, round-robin arbitration, shared FWFT FIFO
// Per-channel holding registers feed one tagged FIFO; late strobes on a busy channel are dropped and counted.
module rx_word_arbiter_1553 #(
  parameter  int NUM_CH     = 2,
  parameter  int DWIDTH     = 16,
  parameter  int FIFO_DEPTH = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk_out,
  input  logic                     reset_slow,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH-1:0]        rx_dval,
  input  logic [NUM_CH-1:0]        rx_csw,
  input  logic [NUM_CH-1:0]        rx_dw,
  input  logic [NUM_CH-1:0]        rx_perr,
  input  logic [NUM_CH*DWIDTH-1:0] rx_dword,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DWIDTH-1:0]        out_word,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_csw,
  output logic                     out_dw,
  output logic                     out_perr,
  output logic [CNT_W-1:0]         fifo_count,
  output logic [NUM_CH-1:0]        drop_pulse,
  output logic [NUM_CH*8-1:0]      drop_cnt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int TAG_W = CH_W + 3;

  // Holding registers: flags packed as {perr, csw, dw}
  logic [NUM_CH-1:0] hold_v_q, hold_v_d;
  logic [DWIDTH-1:0] hold_word_q [NUM_CH];
  logic [DWIDTH-1:0] hold_word_d [NUM_CH];
  logic [2:0]        hold_flag_q [NUM_CH];
  logic [2:0]        hold_flag_d [NUM_CH];

  logic [CH_W-1:0]   rr_q, rr_d;

  logic [DWIDTH-1:0] mem_word_q [FIFO_DEPTH];
  logic [DWIDTH-1:0] mem_word_d [FIFO_DEPTH];
  logic [TAG_W-1:0]  mem_tag_q  [FIFO_DEPTH];
  logic [TAG_W-1:0]  mem_tag_d  [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [NUM_CH-1:0] drop_pulse_q, drop_pulse_d;
  logic [7:0]        drop_cnt_q [NUM_CH];
  logic [7:0]        drop_cnt_d [NUM_CH];

  logic [NUM_CH-1:0] capture;
  logic              pop;
  logic              push_ok;
  logic              gnt_v;
  logic [CH_W-1:0]   gnt_idx;
  logic [TAG_W-1:0]  head_tag;

  assign capture = rx_dval & ch_enable;
  assign pop     = (count_q != '0) && out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign push_ok = (count_q != CNT_W'(FIFO_DEPTH)) || pop;

  always_comb begin
    int              j;
    logic [CH_W-1:0] idx;
    gnt_v   = 1'b0;
    gnt_idx = '0;
    j       = 0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      idx = CH_W'(j);
      if (!gnt_v && hold_v_q[idx] && push_ok) begin
        gnt_v   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    logic granted;
    hold_v_d     = hold_v_q;
    hold_word_d  = hold_word_q;
    hold_flag_d  = hold_flag_q;
    drop_pulse_d = '0;
    drop_cnt_d   = drop_cnt_q;
    granted      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      granted = gnt_v && (gnt_idx == CH_W'(i));
      if (capture[i] && hold_v_q[i] && !granted) begin
        drop_pulse_d[i] = 1'b1;
        if (drop_cnt_q[i] != 8'hFF) drop_cnt_d[i] = drop_cnt_q[i] + 8'd1;
      end else if (capture[i]) begin
        hold_v_d[i]    = 1'b1;
        hold_word_d[i] = rx_dword[i*DWIDTH +: DWIDTH];
        hold_flag_d[i] = {rx_perr[i], rx_csw[i], rx_dw[i]};
      end else if (granted) begin
        hold_v_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_v) rr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    mem_word_d = mem_word_q;
    mem_tag_d  = mem_tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (gnt_v) begin
      mem_word_d[wr_ptr_q] = hold_word_q[gnt_idx];
      mem_tag_d[wr_ptr_q]  = {gnt_idx, hold_flag_q[gnt_idx]};
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({gnt_v, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_out or posedge reset_slow) begin
    if (reset_slow) begin
      hold_v_q     <= '0;
      rr_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_pulse_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_word_q[i] <= '0;
        hold_flag_q[i] <= '0;
        drop_cnt_q[i]  <= '0;
      end
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        mem_word_q[e] <= '0;
        mem_tag_q[e]  <= '0;
      end
    end else begin
      hold_v_q     <= hold_v_d;
      hold_word_q  <= hold_word_d;
      hold_flag_q  <= hold_flag_d;
      rr_q         <= rr_d;
      mem_word_q   <= mem_word_d;
      mem_tag_q    <= mem_tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Head is read straight out of the storage array, so it only moves on a pop
  assign head_tag   = mem_tag_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_word   = mem_word_q[rd_ptr_q];
  assign out_ch     = head_tag[TAG_W-1:3];
  assign out_perr   = head_tag[2];
  assign out_csw    = head_tag[1];
  assign out_dw     = head_tag[0];
  assign fifo_count = count_q;
  assign drop_pulse = drop_pulse_q;

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) drop_cnt[i*8 +: 8] = drop_cnt_q[i];
  end

endmodule

// File: tb/tb_rx_word_arbiter_1553.sv
// tb/tb_rx_word_arbiter_1553.sv - directed scoreboard bench for rx_word_arbiter_1553
// Expected head entries are queued as {ch, perr, csw, dw, word} when the strobe is driven.
module tb_rx_word_arbiter_1553;

  localparam int NUM_CH     = 2;
  localparam int DWIDTH     = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int CH_W       = 1;
  localparam int CNT_W      = 5;

  logic                     clk_out = 1'b0;
  logic                     reset_slow;
  logic [NUM_CH-1:0]        ch_enable;
  logic [NUM_CH-1:0]        rx_dval;
  logic [NUM_CH-1:0]        rx_csw;
  logic [NUM_CH-1:0]        rx_dw;
  logic [NUM_CH-1:0]        rx_perr;
  logic [NUM_CH*DWIDTH-1:0] rx_dword;
  logic                     out_valid;
  logic                     out_ready;
  logic [DWIDTH-1:0]        out_word;
  logic [CH_W-1:0]          out_ch;
  logic                     out_csw;
  logic                     out_dw;
  logic                     out_perr;
  logic [CNT_W-1:0]         fifo_count;
  logic [NUM_CH-1:0]        drop_pulse;
  logic [NUM_CH*8-1:0]      drop_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [19:0] sb[$];

  always #5 clk_out = ~clk_out;

  rx_word_arbiter_1553 #(
    .NUM_CH(NUM_CH), .DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_out(clk_out), .reset_slow(reset_slow), .ch_enable(ch_enable),
    .rx_dval(rx_dval), .rx_csw(rx_csw), .rx_dw(rx_dw), .rx_perr(rx_perr),
    .rx_dword(rx_dword), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_ch(out_ch), .out_csw(out_csw), .out_dw(out_dw),
    .out_perr(out_perr), .fifo_count(fifo_count), .drop_pulse(drop_pulse),
    .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_out);
    #1;
  endtask

  task automatic idle();
    rx_dval = '0;
  endtask

  task automatic strobe(input int ch, input logic [15:0] w, input logic [2:0] f, input bit expect_out);
    rx_dval[ch]            = 1'b1;
    rx_dword[ch*16 +: 16]  = w;
    rx_perr[ch]            = f[2];
    rx_csw[ch]             = f[1];
    rx_dw[ch]              = f[0];
    if (expect_out) sb.push_back({CH_W'(ch), f, w});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (fifo_count != 0 && n < 200) begin
      step();
      n++;
    end
    step();
    step();
    check(tag, 32'(fifo_count), 32'd0);
  endtask

  // Head comparison against the scoreboard whenever a pop will happen at the next edge
  always @(negedge clk_out) begin
    logic [19:0] exp;
    if (!reset_slow && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_underflow observed=%0h expected=none", {out_ch, out_perr, out_csw, out_dw, out_word});
      end else begin
        exp = sb.pop_front();
        check("out_head", 32'({out_ch, out_perr, out_csw, out_dw, out_word}), 32'(exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset_slow = 1'b1;
    ch_enable  = 2'b11;
    rx_dval    = '0;
    rx_csw     = '0;
    rx_dw      = '0;
    rx_perr    = '0;
    rx_dword   = '0;
    out_ready  = 1'b0;
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_word", 32'(out_word), 32'd0);
    check("rst_flags", 32'({out_ch, out_csw, out_dw, out_perr}), 32'd0);
    check("rst_drop_pulse", 32'(drop_pulse), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    reset_slow = 1'b0;
    step();

    // Single word: valid two edges after the strobe
    out_ready = 1'b1;
    strobe(0, 16'h1234, 3'b010, 1);
    step();
    idle();
    check("t1_not_yet", 32'(out_valid), 32'd0);
    step();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_word", 32'(out_word), 32'h1234);
    check("t1_ch", 32'(out_ch), 32'd0);
    check("t1_csw", 32'(out_csw), 32'd1);
    check("t1_count", 32'(fifo_count), 32'd1);
    step();
    check("t1_empty", 32'(fifo_count), 32'd0);

    // Move pointer back to 0, then simultaneous ch0/ch1
    strobe(1, 16'h0101, 3'b001, 1);
    step();
    idle();
    step();
    drain("t2_pre0");
    strobe(0, 16'hAAAA, 3'b010, 1);
    strobe(1, 16'h5555, 3'b001, 1);
    step();
    idle();
    step();
    check("t2_p0_first_word", 32'(out_word), 32'hAAAA);
    check("t2_p0_first_ch", 32'(out_ch), 32'd0);
    step();
    check("t2_p0_second_word", 32'(out_word), 32'h5555);
    check("t2_p0_second_ch", 32'(out_ch), 32'd1);
    drain("t2_p0_drain");

    // Pointer to 1, then simultaneous: ch1 wins
    strobe(0, 16'h0202, 3'b000, 1);
    step();
    idle();
    step();
    drain("t2_pre1");
    strobe(1, 16'hF0F0, 3'b100, 1);
    strobe(0, 16'h0F0F, 3'b000, 1);
    step();
    idle();
    step();
    check("t2_p1_first_word", 32'(out_word), 32'hF0F0);
    check("t2_p1_first_ch", 32'(out_ch), 32'd1);
    step();
    check("t2_p1_second_word", 32'(out_word), 32'h0F0F);
    check("t2_p1_second_ch", 32'(out_ch), 32'd0);
    drain("t2_p1_drain");

    // Backpressure: 20 alternating strobes; words 18/19 dropped
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      idle();
      strobe(k % 2, 16'h3000 + 16'(k), 3'(k % 8), k < 18);
      step();
      if (k == 16) check("t3_full", 32'(fifo_count), 32'd16);
      if (k == 17) check("t3_no_drop_e17", 32'(drop_pulse), 32'b00);
      if (k == 18) check("t3_drop_ch0", 32'(drop_pulse), 32'b01);
      if (k == 19) check("t3_drop_ch1", 32'(drop_pulse), 32'b10);
    end
    idle();
    check("t3_drop_cnt", 32'(drop_cnt), 32'h0101);

    // Full push+pop keeps count at 16 while the held words enter
    out_ready = 1'b1;
    step();
    check("t4_pushpop_count0", 32'(fifo_count), 32'd16);
    check("t4_no_drop", 32'(drop_pulse), 32'b00);
    step();
    check("t4_pushpop_count1", 32'(fifo_count), 32'd16);
    step();
    check("t4_count_dec", 32'(fifo_count), 32'd15);
    drain("t3_drain");

    // Fill with ch0 (same-cycle grant+capture each edge), then block ch1
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idle();
      strobe(0, 16'h5000 + 16'(k), 3'(k % 8), 1);
      step();
    end
    idle();
    step();
    step();
    check("t5_full", 32'(fifo_count), 32'd16);
    check("t5_ch0_no_new_drop", 32'(drop_cnt[7:0]), 32'd1);
    strobe(1, 16'hA5A5, 3'b111, 1);
    step();
    idle();
    step();
    check("t5_hold_no_drop", 32'(drop_pulse), 32'b00);
    for (int k = 0; k < 300; k++) begin
      strobe(1, 16'hD000 + 16'(k), 3'b000, 0);
      step();
      if (k == 0) check("t5_first_drop", 32'(drop_pulse), 32'b10);
    end
    idle();
    step();
    check("t5_sat_ch1", 32'(drop_cnt[15:8]), 32'd255);
    check("t5_ch0_cnt", 32'(drop_cnt[7:0]), 32'd1);
    ch_enable = 2'b10;
    strobe(0, 16'hEEEE, 3'b000, 0);
    step();
    idle();
    step();
    check("t5_dis_no_drop", 32'(drop_pulse), 32'b00);
    check("t5_dis_count", 32'(fifo_count), 32'd16);
    ch_enable = 2'b11;
    out_ready = 1'b1;
    step();
    drain("t5_drain");
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-stream with 5 queued words
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      idle();
      strobe(0, 16'h6000 + 16'(k), 3'b000, 0);
      step();
    end
    idle();
    step();
    step();
    check("t6_queued", 32'(fifo_count), 32'd5);
    reset_slow = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_count", 32'(fifo_count), 32'd0);
    check("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t6_rst_word", 32'(out_word), 32'd0);
    step();
    step();
    reset_slow = 1'b0;
    step();
    out_ready = 1'b1;
    strobe(0, 16'h1111, 3'b010, 1);
    strobe(1, 16'h2222, 3'b001, 1);
    step();
    idle();
    step();
    check("t6_first_ch", 32'(out_ch), 32'd0);
    check("t6_first_word", 32'(out_word), 32'h1111);
    step();
    check("t6_second_ch", 32'(out_ch), 32'd1);
    drain("t6_drain");
    check("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
